// File: rtl/ir_pkg.sv
// ir_pkg: NEC unit counts, transmitter state type and shared attack codes.
package ir_pkg;
  localparam int LDR_MARK_UNITS   = 16;
  localparam int LDR_SPACE_UNITS  = 8;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int STOP_UNITS       = 1;
  localparam logic [31:0] BLOCK_CODE = 32'hDEADBEEF;
  localparam logic [31:0] LUNGE_CODE = 32'h20FACADE;
  typedef enum logic [2:0] {
    IDLE, LDR_MARK, LDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } ir_tx_state_t;
  function automatic logic is_mark(ir_tx_state_t s);
    return s inside {LDR_MARK, BIT_MARK, STOP_MARK};
  endfunction
endpackage

// File: rtl/ir_nec_transmitter_if.sv
// ir_nec_transmitter_if: code handshake between the attack logic and the NEC transmitter.
interface ir_nec_transmitter_if;
  logic [31:0] code_in;
  logic        code_valid_in;
  logic        ready_out;
  modport master (output code_in, code_valid_in, input ready_out);
  modport slave  (input code_in, code_valid_in, output ready_out);
endinterface

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: 50% duty carrier that restarts high on every mark start.
module ir_carrier_gen #(
  parameter int HALF_CYCLES = 977
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic carrier_o
);
  logic [15:0] cnt_q;
  logic        car_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      car_q <= 1'b0;
    end else if (restart_i) begin
      cnt_q <= '0;
      car_q <= 1'b1;
    end else if (cnt_q == 16'(HALF_CYCLES - 1)) begin
      cnt_q <= '0;
      car_q <= ~car_q;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
  assign carrier_o = car_q;
endmodule

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter: serialises a 32-bit code LSB-first as an NEC frame on ir_out.
// Define IR_CARRIER_EN to modulate marks with the carrier; otherwise ir_out is the raw envelope.
module ir_nec_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES         = 41766,
  parameter int CARRIER_HALF_CYCLES = 977,
  parameter int GAP_UNITS           = 16
) (
  input  logic                 clk_pixel_in,
  input  logic                 rst_n_in,
  ir_nec_transmitter_if.slave  tx,
  output logic                 busy_out,
  output logic                 mark_out,
  output logic                 ir_out,
  output logic                 done_out
);
  localparam int CW = $clog2(UNIT_CYCLES + 1);

  if (UNIT_CYCLES < 2 || CARRIER_HALF_CYCLES < 1 || GAP_UNITS < 1 || GAP_UNITS > 31) begin : g_bad_param
    $error("ir_nec_transmitter: parameter out of range");
  end

  ir_tx_state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    unit_q, unit_d, bit_q, bit_d, seg_len;
  logic [31:0]   shift_q, shift_d;
  logic          ready_q, done_q, unit_wrap, seg_end;

  // Segment length in units; a BIT_SPACE length depends on the bit being sent.
  assign seg_len = state_q == LDR_MARK  ? 5'(LDR_MARK_UNITS)  :
                   state_q == LDR_SPACE ? 5'(LDR_SPACE_UNITS) :
                   state_q == BIT_SPACE ? (shift_q[0] ? 5'(ONE_SPACE_UNITS) : 5'(ZERO_SPACE_UNITS)) :
                   state_q == STOP_MARK ? 5'(STOP_UNITS)      :
                   state_q == GAP       ? 5'(GAP_UNITS)       : 5'd1;
  assign unit_wrap = cyc_q == CW'(UNIT_CYCLES - 1);
  assign seg_end   = unit_wrap && unit_q == seg_len - 5'd1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (tx.code_valid_in && ready_q) begin
        state_d = LDR_MARK;
        shift_d = tx.code_in;
      end
      LDR_MARK:  if (seg_end) state_d = LDR_SPACE;
      LDR_SPACE: if (seg_end) state_d = BIT_MARK;
      BIT_MARK:  if (seg_end) state_d = BIT_SPACE;
      BIT_SPACE: if (seg_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 5'd1;
        state_d = bit_q == 5'd31 ? STOP_MARK : BIT_MARK;
      end
      STOP_MARK: if (seg_end) state_d = GAP;
      GAP:       if (seg_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    cyc_d  = (state_d != state_q || unit_wrap) ? '0 : cyc_q + CW'(1);
    unit_d = state_d != state_q ? '0 : unit_q + 5'(unit_wrap);
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= state_d == IDLE;
      done_q  <= state_q == GAP && state_d == IDLE;
    end
  end

  assign tx.ready_out = ready_q;
  assign busy_out     = state_q != IDLE;
  assign mark_out     = is_mark(state_q);
  assign done_out     = done_q;

`ifdef IR_CARRIER_EN
  logic carrier;
  ir_carrier_gen #(.HALF_CYCLES(CARRIER_HALF_CYCLES)) u_carrier (
    .clk       (clk_pixel_in),
    .rst_n     (rst_n_in),
    .restart_i (is_mark(state_d) && !is_mark(state_q)),
    .carrier_o (carrier)
  );
  assign ir_out = mark_out & carrier;
`else
  assign ir_out = mark_out;
`endif
endmodule

// File: tb/tb_ir_nec_transmitter.sv
// tb_ir_nec_transmitter: directed checks of NEC framing, handshake and mid-frame reset.
module tb_ir_nec_transmitter;
  localparam logic [31:0] BLOCK = 32'hDEADBEEF;
  localparam logic [31:0] LUNGE = 32'h20FACADE;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, mark, ir, done;
  int checks = 0;
  int errors = 0;

  ir_nec_transmitter_if bus ();

  ir_nec_transmitter #(
    .UNIT_CYCLES(4), .CARRIER_HALF_CYCLES(1), .GAP_UNITS(4)
  ) dut (
    .clk_pixel_in (clk),
    .rst_n_in     (rst_n),
    .tx           (bus),
    .busy_out     (busy),
    .mark_out     (mark),
    .ir_out       (ir),
    .done_out     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records mark_out for the whole busy period, then decodes the envelope.
  task automatic capture(input int pulse_at, input bit hold, output int n,
                         output logic [31:0] dec, output int bad);
    logic mbuf [0:1023];
    int pos, len;
    n = 0;
    while (busy === 1'b1 && n < 1024) begin
      mbuf[n] = mark;
      if (n == pulse_at) begin
        bus.code_in = 32'h12345678;
        bus.code_valid_in = 1'b1;
      end else if (!hold) bus.code_valid_in = 1'b0;
      n++;
      @(negedge clk);
    end
    bad = 0;
    dec = '0;
    for (int i = 0; i < 96; i++) if (i >= n || mbuf[i] !== (i < 64)) bad++;
    pos = 96;
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < 4; k++) if (pos + k >= n || mbuf[pos + k] !== 1'b1) bad++;
      pos += 4;
      len = 0;
      while (pos < n && mbuf[pos] === 1'b0) begin
        len++;
        pos++;
      end
      dec[b] = len == 12;
      if (len != 4 && len != 12) bad++;
    end
    for (int k = 0; k < 4; k++) if (pos + k >= n || mbuf[pos + k] !== 1'b1) bad++;
    if (n - pos != 20) bad++;
  endtask

  initial begin
    int n, bad;
    logic [31:0] dec;
    rst_n = 1'b1;
    bus.code_in = '0;
    bus.code_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mark", mark, 0);
    chk("rst_ir", ir, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.ready_out, 1);
    chk("rel_busy", busy, 0);
    chk("rel_ir", ir, 0);

    bus.code_in = BLOCK;
    bus.code_valid_in = 1'b1;
    @(negedge clk);
    bus.code_valid_in = 1'b0;
    chk("f1_start_busy", busy, 1);
    chk("f1_start_mark", mark, 1);
    chk("f1_start_ir", ir, 1);
    chk("f1_start_ready", bus.ready_out, 0);
    capture(-1, 1'b0, n, dec, bad);
    chk("f1_len", n, 564);
    chk("f1_code", dec, BLOCK);
    chk("f1_fmt", bad, 0);
    chk("f1_done", done, 1);
    chk("f1_ready", bus.ready_out, 1);
    @(negedge clk);
    chk("f1_done_pulse", done, 0);

    bus.code_in = LUNGE;
    bus.code_valid_in = 1'b1;
    @(negedge clk);
    bus.code_valid_in = 1'b0;
    chk("f2_start_busy", busy, 1);
    capture(300, 1'b0, n, dec, bad);
    chk("f2_len", n, 508);
    chk("f2_code", dec, LUNGE);
    chk("f2_fmt", bad, 0);
    chk("f2_done", done, 1);
    @(negedge clk);

    bus.code_in = BLOCK;
    bus.code_valid_in = 1'b1;
    @(negedge clk);
    bus.code_in = LUNGE;
    capture(-1, 1'b1, n, dec, bad);
    chk("b2b1_len", n, 564);
    chk("b2b1_code", dec, BLOCK);
    chk("b2b1_done", done, 1);
    chk("b2b1_ready", bus.ready_out, 1);
    @(negedge clk);
    bus.code_valid_in = 1'b0;
    chk("b2b2_busy", busy, 1);
    chk("b2b2_mark", mark, 1);
    chk("b2b2_ready", bus.ready_out, 0);
    chk("b2b2_done", done, 0);
    capture(-1, 1'b0, n, dec, bad);
    chk("b2b2_len", n, 508);
    chk("b2b2_code", dec, LUNGE);
    @(negedge clk);

    bus.code_in = 32'h0;
    bus.code_valid_in = 1'b1;
    @(negedge clk);
    bus.code_valid_in = 1'b0;
    repeat (176) @(negedge clk);
    chk("bit10_mark", mark, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_mark", mark, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", bus.ready_out, 1);
    bus.code_in = LUNGE;
    bus.code_valid_in = 1'b1;
    @(negedge clk);
    bus.code_valid_in = 1'b0;
    chk("post_rst_ir", ir, 1);
    capture(-1, 1'b0, n, dec, bad);
    chk("post_rst_len", n, 508);
    chk("post_rst_code", dec, LUNGE);
    chk("post_rst_fmt", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
